// File: rtl/if_fetch_stage_if.sv
// ----------------------------------------------------------------------------
// if_fetch_stage_if
// Instruction-memory bus between the fetch stage (master) and a
// variable-latency instruction memory (slave). At most one request is
// outstanding, and responses return in order.
// ----------------------------------------------------------------------------
interface if_fetch_stage_if #(
    parameter int PC_W    = 9,
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_valid;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_valid,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
// Instruction-fetch stage feeding the IF/ID pipeline register. It owns the
// PC, keeps one fetch in flight, absorbs stalls and redirects, and presents
// NOP_INSTR whenever no real instruction is available.
//
// Optional feature: define IF_PERF_CNT_EN to add the fetch_cnt and
// redirect_cnt performance counters.
// ----------------------------------------------------------------------------
module if_fetch_stage #(
    parameter int                 PC_W      = 9,
    parameter int                 INSTR_W   = 32,
    parameter logic [PC_W-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_W-1:0]     redirect_pc,
    if_fetch_stage_if.master    imem,
    output logic [PC_W-1:0]     PC,
    output logic [PC_W-1:0]     PCPlus4,
    output logic [INSTR_W-1:0]  Instr,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]         fetch_cnt,
    output logic [31:0]         redirect_cnt,
`endif
    output logic                fetch_valid
);

    typedef enum logic [1:0] {
        S_FETCH,   // ready to issue a request at r_pc
        S_WAIT,    // request outstanding, response wanted
        S_HOLD,    // instruction in r_ibuf, presented to IF/ID
        S_DROP     // request outstanding, response is stale
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    w_pc_next;
    logic [PC_W-1:0]    w_pc_plus4;
    logic [PC_W-1:0]    w_redirect_aligned;
    logic [INSTR_W-1:0] r_ibuf;
    logic               w_ibuf_load;
    logic               w_req;
    logic [PC_W-1:0]    w_addr;
    logic               w_present;

    // Additions wrap naturally at PC_W bits.
    assign w_pc_plus4         = r_pc + PC_W'(4);
    assign w_redirect_aligned = {redirect_pc[PC_W-1:2], 2'b00};

    // State, PC and instruction buffer registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_ibuf  <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_pc_next;
            if (w_ibuf_load) begin
                r_ibuf <= imem.imem_rdata;
            end
        end
    end

    // Next-state, next-PC and memory request decode.
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_pc_next    = r_pc;
        w_ibuf_load  = 1'b0;
        w_req        = 1'b0;
        w_addr       = r_pc;
        case (r_state)
            S_FETCH: begin
                if (redirect) begin
                    w_pc_next = w_redirect_aligned;
                end else begin
                    w_req        = 1'b1;
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem.imem_valid) begin
                    if (redirect) begin
                        w_pc_next    = w_redirect_aligned;
                        w_next_state = S_FETCH;
                    end else begin
                        w_ibuf_load  = 1'b1;
                        w_next_state = S_HOLD;
                    end
                end else if (redirect) begin
                    w_pc_next    = w_redirect_aligned;
                    w_next_state = S_DROP;
                end
            end
            S_HOLD: begin
                // Redirect wins over stall: the held instruction is wrong-path.
                if (redirect) begin
                    w_pc_next    = w_redirect_aligned;
                    w_next_state = S_FETCH;
                end else if (!stall) begin
                    // IF/ID captures now; overlap the next fetch.
                    w_req        = 1'b1;
                    w_addr       = w_pc_plus4;
                    w_pc_next    = w_pc_plus4;
                    w_next_state = S_WAIT;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    w_pc_next = w_redirect_aligned;
                end
                if (imem.imem_valid) begin
                    w_next_state = S_FETCH;
                end
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    // Requests are suppressed while reset is held so the memory, reset
    // alongside us, never sees a request it would then lose.
    assign imem.imem_req  = w_req & ~reset;
    assign imem.imem_addr = w_addr;

    // A same-cycle redirect masks the presented instruction.
    assign w_present   = (r_state == S_HOLD) && !redirect;
    assign fetch_valid = w_present;
    assign Instr       = w_present ? r_ibuf : NOP_INSTR;
    assign PC          = r_pc;
    assign PCPlus4     = w_pc_plus4;

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_redirect_cnt;

    // Performance counters: instructions consumed by IF/ID and redirects seen.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_cnt    <= '0;
            r_redirect_cnt <= '0;
        end else begin
            if ((r_state == S_HOLD) && !stall && !redirect) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (redirect) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt    = r_fetch_cnt;
    assign redirect_cnt = r_redirect_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_stage
// Directed bench for if_fetch_stage with a behavioural instruction memory
// of selectable latency returning rdata = addr | 0x1000_0000. Expected
// request addresses and consumed instructions are queued ahead of each
// phase and popped as the DUT produces them.
// ----------------------------------------------------------------------------
module tb_if_fetch_stage;

    localparam int              PC_W      = 9;
    localparam int              INSTR_W   = 32;
    localparam logic [31:0]     NOP       = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              stall = 1'b0;
    logic              redirect = 1'b0;
    logic [PC_W-1:0]   redirect_pc = '0;
    logic [PC_W-1:0]   PC;
    logic [PC_W-1:0]   PCPlus4;
    logic [31:0]       Instr;
    logic              fetch_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0]       fetch_cnt;
    logic [31:0]       redirect_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int lat   = 1;
    int exp_fetches   = 0;
    int exp_redirects = 0;

    logic [PC_W-1:0] exp_addr_q[$];
    logic [PC_W-1:0] exp_fetch_q[$];

    if_fetch_stage_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) imem_bus ();

    if_fetch_stage #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (9'h000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem_bus.master),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .Instr       (Instr),
`ifdef IF_PERF_CNT_EN
        .fetch_cnt   (fetch_cnt),
        .redirect_cnt(redirect_cnt),
`endif
        .fetch_valid (fetch_valid)
    );

    always #5 clk = ~clk;

    // Behavioural memory: response strobe 'lat' cycles after the request.
    int              m_cnt = 0;
    logic [PC_W-1:0] m_addr = '0;
    initial imem_bus.imem_valid = 1'b0;
    always @(posedge clk) begin
        if (reset) begin
            m_cnt               <= 0;
            imem_bus.imem_valid <= 1'b0;
        end else if (imem_bus.imem_req) begin
            m_addr              <= imem_bus.imem_addr;
            m_cnt               <= lat;
            imem_bus.imem_valid <= (lat == 1);
        end else if (m_cnt > 0) begin
            m_cnt               <= m_cnt - 1;
            imem_bus.imem_valid <= (m_cnt == 2);
        end else begin
            imem_bus.imem_valid <= 1'b0;
        end
    end
    assign imem_bus.imem_rdata = {23'b0, m_addr} | 32'h1000_0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Per-cycle scoreboard: requests and consumed instructions in order.
    task automatic monitor();
        logic [PC_W-1:0] a;
        if (imem_bus.imem_req) begin
            if (exp_addr_q.size() == 0) begin
                check("unexpected_req", 32'(imem_bus.imem_req), 32'd0);
            end else begin
                a = exp_addr_q.pop_front();
                check("req_addr", 32'(imem_bus.imem_addr), 32'(a));
            end
        end
        if (fetch_valid && !stall) begin
            if (exp_fetch_q.size() == 0) begin
                check("unexpected_fetch", 32'(fetch_valid), 32'd0);
            end else begin
                a = exp_fetch_q.pop_front();
                check("fetch_pc", 32'(PC), 32'(a));
                check("fetch_pcplus4", 32'(PCPlus4), 32'(9'(a + 9'd4)));
                check("fetch_instr", Instr, {23'b0, a} | 32'h1000_0000);
                exp_fetches++;
            end
        end
        if (!fetch_valid) begin
            check("bubble_is_nop", Instr, NOP);
        end
    endtask

    // One cycle: inputs applied just after the edge, outputs sampled 1 later.
    task automatic step(input logic st, input logic rd, input logic [PC_W-1:0] rpc);
        @(posedge clk);
        #1;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        if (rd) exp_redirects++;
        #1;
        monitor();
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(imem_bus.imem_req), 32'd0);
        check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        check("rst_instr", Instr, NOP);
        check("rst_pc", 32'(PC), 32'h000);
        check("rst_pcplus4", 32'(PCPlus4), 32'h004);

        // 1-cycle memory streaming from 0x000.
        exp_addr_q.push_back(9'h000);
        exp_addr_q.push_back(9'h004);
        exp_addr_q.push_back(9'h008);
        exp_fetch_q.push_back(9'h000);
        exp_fetch_q.push_back(9'h004);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("c0_req", 32'(imem_bus.imem_req), 32'd1);
        monitor();
        step(1'b0, 1'b0, '0);                    // cycle 1: WAIT
        check("c1_fetch_valid", 32'(fetch_valid), 32'd0);
        step(1'b0, 1'b0, '0);                    // cycle 2: HOLD 0x000
        check("c2_fetch_valid", 32'(fetch_valid), 32'd1);
        repeat (3) step(1'b0, 1'b0, '0);         // cycles 3..5

        // Stall held three cycles in HOLD at 0x008.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, '0);                // cycles 6..8
            check("stall_fetch_valid", 32'(fetch_valid), 32'd1);
            check("stall_pc", 32'(PC), 32'h008);
            check("stall_instr", Instr, 32'h1000_0008);
            check("stall_no_req", 32'(imem_bus.imem_req), 32'd0);
        end
        exp_addr_q.push_back(9'h00C);
        exp_fetch_q.push_back(9'h008);
        lat = 3;
        step(1'b0, 1'b0, '0);                    // cycle 9: release, req 0x00C
        check("release_req", 32'(imem_bus.imem_req), 32'd1);

        // Redirect to 0x0A2 while waiting on a 3-cycle response.
        step(1'b0, 1'b1, 9'h0A2);                // cycle 10: WAIT -> DROP
        check("drop_fetch_valid", 32'(fetch_valid), 32'd0);
        step(1'b0, 1'b0, '0);                    // cycle 11: DROP
        step(1'b0, 1'b0, '0);                    // cycle 12: stale response
        check("stale_valid_seen", 32'(imem_bus.imem_valid), 32'd1);
        check("stale_discarded", 32'(fetch_valid), 32'd0);
        exp_addr_q.push_back(9'h0A0);
        step(1'b0, 1'b0, '0);                    // cycle 13: req 0x0A0
        check("redir_req", 32'(imem_bus.imem_req), 32'd1);
        repeat (3) step(1'b0, 1'b0, '0);         // cycles 14..16

        // Redirect together with stall while holding 0x0A0.
        lat = 1;
        step(1'b1, 1'b1, 9'h100);                // cycle 17: HOLD masked
        check("hold_redir_fv", 32'(fetch_valid), 32'd0);
        check("hold_redir_instr", Instr, NOP);
        exp_addr_q.push_back(9'h100);
        step(1'b0, 1'b0, '0);                    // cycle 18: req 0x100
        check("hold_redir_req", 32'(imem_bus.imem_req), 32'd1);

        // Redirect coincident with the response: data dropped, run from 0x1F8.
        step(1'b0, 1'b1, 9'h1F8);                // cycle 19: WAIT valid+redirect
        check("wait_redir_fv", 32'(fetch_valid), 32'd0);
        exp_addr_q.push_back(9'h1F8);
        exp_addr_q.push_back(9'h1FC);
        exp_addr_q.push_back(9'h000);
        exp_addr_q.push_back(9'h004);
        exp_fetch_q.push_back(9'h1F8);
        exp_fetch_q.push_back(9'h1FC);
        exp_fetch_q.push_back(9'h000);
        repeat (4) step(1'b0, 1'b0, '0);         // cycles 20..23
        step(1'b0, 1'b0, '0);                    // cycle 24: HOLD 0x1FC
        check("wrap_pc", 32'(PC), 32'h1FC);
        check("wrap_pcplus4", 32'(PCPlus4), 32'h000);
        repeat (3) step(1'b0, 1'b0, '0);         // cycles 25..27

        check("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
        check("fetch_q_empty", 32'(exp_fetch_q.size()), 32'd0);

`ifdef IF_PERF_CNT_EN
        check("fetch_cnt", fetch_cnt, 32'(exp_fetches));
        check("redirect_cnt", redirect_cnt, 32'(exp_redirects));
`endif

        // Reset pulse mid-fetch.
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst2_req", 32'(imem_bus.imem_req), 32'd0);
        check("rst2_pc", 32'(PC), 32'h000);
        check("rst2_fetch_valid", 32'(fetch_valid), 32'd0);
`ifdef IF_PERF_CNT_EN
        check("rst2_fetch_cnt", fetch_cnt, 32'd0);
        check("rst2_redirect_cnt", redirect_cnt, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
